// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared constants and state type for the sink-check BFS responder
package sub_pkg;

   localparam int GRID_BITS_DEFAULT = 3;

   // Board cell codes
   localparam logic [1:0] CELL_WATER = 2'b00;
   localparam logic [1:0] CELL_SHIP  = 2'b01;
   localparam logic [1:0] CELL_HIT   = 2'b10;
   localparam logic [1:0] CELL_MISS  = 2'b11;

   // Neighbour visit order around the current cell
   localparam logic [1:0] DIR_XM = 2'd0;
   localparam logic [1:0] DIR_XP = 2'd1;
   localparam logic [1:0] DIR_YM = 2'd2;
   localparam logic [1:0] DIR_YP = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      NEIGH,
      WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/bfs_queue.sv
// rtl/bfs_queue.sv - first-word-fall-through FIFO of cell indices with synchronous clear
module bfs_queue #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;
   logic [AW-1:0]    w_wr_addr;

   // A clear restarts the queue at slot 0, so a push in the same cycle lands there
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_do_push = i_push && (i_clr || !w_full);
   assign w_do_pop  = i_pop && !o_empty && !i_clr;
   assign w_wr_addr = i_clr ? '0 : r_wptr;
   assign o_data    = r_mem[r_rptr];
   assign o_empty   = (r_count == '0);

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_rptr  <= '0;
         r_wptr  <= w_do_push ? AW'(1) : '0;
         r_count <= w_do_push ? (AW+1)'(1) : '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_wr_addr] <= i_data;
      end
   end

endmodule

// File: rtl/sub_sink_bfs.sv
// rtl/sub_sink_bfs.sv - flood-fill responder deciding whether the struck ship is sunk
module sub_sink_bfs
   import sub_pkg::*;
#(
   parameter int GRID_BITS = GRID_BITS_DEFAULT,
   parameter int QDEPTH    = 2 ** (2 * GRID_BITS)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 bfs_start,
   input  logic [GRID_BITS-1:0] start_x,
   input  logic [GRID_BITS-1:0] start_y,
   output logic [GRID_BITS-1:0] bfs_x,
   output logic [GRID_BITS-1:0] bfs_y,
   output logic                 bfs_rd,
   input  logic [1:0]           bfs_data,
   input  logic                 bfs_data_valid,
   output logic                 busy,
   output logic                 bfs_done,
   output logic                 bfs_sink
);

   localparam int IW    = 2 * GRID_BITS;
   localparam int CELLS = 1 << IW;
   localparam logic [GRID_BITS-1:0] MAXC = '1;

   state_t               r_state;
   logic [IW-1:0]        r_cur;
   logic [1:0]           r_dir;
   logic [CELLS-1:0]     r_visited;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_sink;
   logic                 r_rd;
   logic [GRID_BITS-1:0] r_x;
   logic [GRID_BITS-1:0] r_y;

   logic [GRID_BITS-1:0] w_cx;
   logic [GRID_BITS-1:0] w_cy;
   logic [GRID_BITS-1:0] w_nx;
   logic [GRID_BITS-1:0] w_ny;
   logic                 w_on_board;
   logic [IW-1:0]        w_nidx;
   logic                 w_seen;
   logic                 w_last_dir;

   logic                 w_q_clr;
   logic                 w_q_push;
   logic                 w_q_pop;
   logic [IW-1:0]        w_q_din;
   logic [IW-1:0]        w_q_dout;
   logic                 w_q_empty;

   assign w_cx       = r_cur[GRID_BITS-1:0];
   assign w_cy       = r_cur[IW-1:GRID_BITS];
   assign w_nidx     = {w_ny, w_nx};
   assign w_seen     = r_visited[w_nidx];
   assign w_last_dir = (r_dir == DIR_YP);

   // Neighbour coordinate for the current direction; edges do not wrap
   always_comb begin
      w_nx       = w_cx;
      w_ny       = w_cy;
      w_on_board = 1'b0;
      case (r_dir)
         DIR_XM: begin
            w_on_board = (w_cx != '0);
            w_nx       = w_cx - GRID_BITS'(1);
         end
         DIR_XP: begin
            w_on_board = (w_cx != MAXC);
            w_nx       = w_cx + GRID_BITS'(1);
         end
         DIR_YM: begin
            w_on_board = (w_cy != '0);
            w_ny       = w_cy - GRID_BITS'(1);
         end
         default: begin
            w_on_board = (w_cy != MAXC);
            w_ny       = w_cy + GRID_BITS'(1);
         end
      endcase
   end

   // Queue control: a start flushes stale entries and seeds the struck cell;
   // a hit neighbour is enqueued straight from the held read address
   always_comb begin
      w_q_clr  = (r_state == IDLE) && bfs_start;
      w_q_push = w_q_clr ||
                 ((r_state == WAIT) && bfs_data_valid && (bfs_data == CELL_HIT));
      w_q_din  = w_q_clr ? {start_y, start_x} : {r_y, r_x};
      w_q_pop  = (r_state == POP) && !w_q_empty;
   end

   bfs_queue #(
      .WIDTH (IW),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_q_clr),
      .i_push  (w_q_push),
      .i_data  (w_q_din),
      .i_pop   (w_q_pop),
      .o_data  (w_q_dout),
      .o_empty (w_q_empty)
   );

   // Traversal state machine with registered handshake and read outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_cur     <= '0;
         r_dir     <= DIR_XM;
         r_visited <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sink    <= 1'b0;
         r_rd      <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
      end else begin
         r_rd   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bfs_start) begin
                  r_visited                     <= '0;
                  r_visited[{start_y, start_x}] <= 1'b1;
                  r_sink                        <= 1'b0;
                  r_busy                        <= 1'b1;
                  r_state                       <= POP;
               end
            end
            POP: begin
               if (w_q_empty) begin
                  r_sink  <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_cur   <= w_q_dout;
                  r_dir   <= DIR_XM;
                  r_state <= NEIGH;
               end
            end
            NEIGH: begin
               if (!w_on_board || w_seen) begin
                  if (w_last_dir) begin
                     r_state <= POP;
                  end else begin
                     r_dir <= r_dir + 2'd1;
                  end
               end else begin
                  r_x               <= w_nx;
                  r_y               <= w_ny;
                  r_rd              <= 1'b1;
                  r_visited[w_nidx] <= 1'b1;
                  r_state           <= WAIT;
               end
            end
            WAIT: begin
               if (bfs_data_valid) begin
                  if (bfs_data == CELL_SHIP) begin
                     r_sink  <= 1'b0;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= DONE;
                  end else if (w_last_dir) begin
                     r_state <= POP;
                  end else begin
                     r_dir   <= r_dir + 2'd1;
                     r_state <= NEIGH;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bfs_x    = r_x;
   assign bfs_y    = r_y;
   assign bfs_rd   = r_rd;
   assign busy     = r_busy;
   assign bfs_done = r_done;
   assign bfs_sink = r_sink;

endmodule

// File: tb/tb_sub_sink_bfs.sv
// tb/tb_sub_sink_bfs.sv - self-checking bench for sub_sink_bfs with a board-memory model
module tb_sub_sink_bfs;

   logic       clk = 1'b0;
   logic       rstn;
   logic       bfs_start;
   logic [2:0] start_x;
   logic [2:0] start_y;
   logic [2:0] bfs_x;
   logic [2:0] bfs_y;
   logic       bfs_rd;
   logic [1:0] bfs_data;
   logic       bfs_data_valid;
   logic       busy;
   logic       bfs_done;
   logic       bfs_sink;

   int checks   = 0;
   int failures = 0;

   logic [1:0] board [64];
   int         lat = 1;
   int         rd_log [$];
   bit         pend = 0;
   int         cnt = 0;
   int         paddr = 0;
   int         stable_err = 0;
   int         done_cnt = 0;
   int         done_busy_err = 0;

   always #5 clk = ~clk;

   sub_sink_bfs dut (
      .clk            (clk),
      .rstn           (rstn),
      .bfs_start      (bfs_start),
      .start_x        (start_x),
      .start_y        (start_y),
      .bfs_x          (bfs_x),
      .bfs_y          (bfs_y),
      .bfs_rd         (bfs_rd),
      .bfs_data       (bfs_data),
      .bfs_data_valid (bfs_data_valid),
      .busy           (busy),
      .bfs_done       (bfs_done),
      .bfs_sink       (bfs_sink)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Board memory: answers each read after lat cycles, not reset with the DUT
   initial begin
      bfs_data       = 2'b00;
      bfs_data_valid = 1'b0;
      forever begin
         @(negedge clk);
         bfs_data_valid = 1'b0;
         if (pend) begin
            if (busy && ({bfs_y, bfs_x} !== 6'(paddr))) stable_err++;
            if (cnt <= 1) begin
               bfs_data       = board[paddr];
               bfs_data_valid = 1'b1;
               pend           = 0;
            end else begin
               cnt--;
            end
         end
         if (bfs_rd === 1'b1) begin
            rd_log.push_back(int'({bfs_y, bfs_x}));
            paddr = int'({bfs_y, bfs_x});
            cnt   = lat;
            pend  = 1;
         end
         if (bfs_done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0) done_busy_err++;
         end
      end
   end

   // Component view: sunk iff the ship component of the start holds no intact cell;
   // a sunk search reads every cell of the component or bordering it, except the start
   task automatic ref_eval(input int sx, input int sy, output bit sink, output int nreads);
      bit comp [64];
      bit touched [64];
      int q [$];
      int dxs [4] = '{-1, 1, 0, 0};
      int dys [4] = '{0, 0, -1, 1};
      int st;
      st   = sy * 8 + sx;
      sink = 1;
      foreach (comp[i]) begin
         comp[i]    = 0;
         touched[i] = 0;
      end
      comp[st] = 1;
      q.push_back(st);
      while (q.size() > 0) begin
         int c;
         c = q.pop_front();
         for (int d = 0; d < 4; d++) begin
            int nx;
            int ny;
            int n;
            nx = (c % 8) + dxs[d];
            ny = (c / 8) + dys[d];
            if (nx < 0 || nx > 7 || ny < 0 || ny > 7) continue;
            n = ny * 8 + nx;
            touched[n] = 1;
            if (board[n] == 2'b01) sink = 0;
            if (!comp[n] && (board[n] == 2'b01 || board[n] == 2'b10)) begin
               comp[n] = 1;
               q.push_back(n);
            end
         end
      end
      nreads = 0;
      for (int i = 0; i < 64; i++) begin
         if ((comp[i] || touched[i]) && i != st) nreads++;
      end
   endtask

   task automatic verify(input string tag, input int sx, input int sy, input bit extra);
      bit exp_sink;
      int exp_reads;
      int n;
      int dups;
      int start_reads;
      bit seen [64];
      bit got_sink;
      ref_eval(sx, sy, exp_sink, exp_reads);
      rd_log.delete();
      done_cnt      = 0;
      stable_err    = 0;
      done_busy_err = 0;
      @(negedge clk);
      bfs_start = 1'b1;
      start_x   = 3'(sx);
      start_y   = 3'(sy);
      @(negedge clk);
      bfs_start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
      n = 0;
      while (bfs_done !== 1'b1 && n < 5000) begin
         if (extra && busy === 1'b1 && (n % 5) == 2) begin
            bfs_start = 1'b1;
            start_x   = 3'($urandom);
            start_y   = 3'($urandom);
         end
         @(negedge clk);
         bfs_start = 1'b0;
         n++;
      end
      check({tag, "_timeout"}, (n >= 5000), 0);
      got_sink = bfs_sink;
      check({tag, "_sink"}, got_sink, exp_sink);
      @(negedge clk);
      @(negedge clk);
      check({tag, "_sink_held"}, bfs_sink, exp_sink);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_busy_low_at_done"}, done_busy_err, 0);
      check({tag, "_addr_stable"}, stable_err, 0);
      foreach (seen[i]) seen[i] = 0;
      dups        = 0;
      start_reads = 0;
      foreach (rd_log[i]) begin
         if (seen[rd_log[i]]) dups++;
         seen[rd_log[i]] = 1;
         if (rd_log[i] == sy * 8 + sx) start_reads++;
      end
      check({tag, "_dup_reads"}, dups, 0);
      check({tag, "_start_read"}, start_reads, 0);
      if (exp_sink) begin
         check({tag, "_read_count"}, rd_log.size(), exp_reads);
      end else begin
         check({tag, "_last_read_intact"},
               (rd_log.size() > 0) ? int'(board[rd_log[rd_log.size()-1]]) : -1, 1);
      end
   endtask

   task automatic clear_board();
      foreach (board[i]) board[i] = 2'b00;
   endtask

   task automatic line_board(input logic [1:0] third);
      clear_board();
      board[3*8+1] = 2'b10;
      board[3*8+2] = 2'b10;
      board[3*8+3] = third;
   endtask

   initial begin
      int n;
      rstn      = 1'b0;
      bfs_start = 1'b0;
      start_x   = '0;
      start_y   = '0;
      clear_board();
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", {busy, bfs_done, bfs_sink, bfs_rd, bfs_y, bfs_x}, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Lone ship, four water neighbours
      lat = 1;
      clear_board();
      board[2*8+2] = 2'b10;
      verify("single", 2, 2, 0);

      // Hit chain ending in an intact cell
      line_board(2'b01);
      verify("intact", 1, 3, 0);
      check("intact_last_addr", (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : -1, 3*8+3);

      // Whole ship hit
      line_board(2'b10);
      verify("fullhit", 1, 3, 0);

      // Corner start reads only on-board neighbours, in direction order
      clear_board();
      board[0] = 2'b10;
      verify("corner", 0, 0, 0);
      check("corner_rd0", (rd_log.size() > 0) ? rd_log[0] : -1, 1);
      check("corner_rd1", (rd_log.size() > 1) ? rd_log[1] : -1, 8);

      // Slow memory with spurious starts while busy
      lat = 3;
      line_board(2'b10);
      verify("slow", 1, 3, 1);

      // Reset while a read is outstanding
      rd_log.delete();
      done_cnt = 0;
      @(negedge clk);
      bfs_start = 1'b1;
      start_x   = 3'd1;
      start_y   = 3'd3;
      @(negedge clk);
      bfs_start = 1'b0;
      n = 0;
      while (rd_log.size() == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("midreset_read_seen", (rd_log.size() > 0), 1);
      rstn = 1'b0;
      #1;
      check("midreset_outputs", {busy, bfs_done, bfs_sink, bfs_rd, bfs_y, bfs_x}, 0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      check("stale_valid_delivered", pend, 0);
      check("stale_valid_ignored", {busy, bfs_done, bfs_rd}, 0);
      check("stale_no_new_reads", rd_log.size(), 1);
      check("stale_no_done", done_cnt, 0);

      lat = 1;
      clear_board();
      board[2*8+2] = 2'b10;
      verify("after_reset", 2, 2, 0);

      // Random boards, latencies and start cells
      for (int t = 0; t < 20; t++) begin
         int sx;
         int sy;
         lat = $urandom_range(1, 4);
         foreach (board[i]) begin
            int r;
            r = $urandom_range(0, 9);
            board[i] = (r < 5) ? 2'b00 : (r < 7) ? 2'b10 : (r < 8) ? 2'b01 : 2'b11;
         end
         sx = $urandom_range(0, 7);
         sy = $urandom_range(0, 7);
         board[sy*8+sx] = 2'b10;
         verify($sformatf("rand%0d", t), sx, sy, bit'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
